// File: rtl/instruction_queue.sv
// instruction_queue: byte-granular prefetch queue feeding a 16-byte decode window.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_fetch_valid/data/count   1..4 little-endian bytes from the bus unit
//   o_fetch_ready         at least 4 bytes free
//   o_instruction[0:15]   oldest 16 bytes, zero beyond the held count
//   o_available           bytes held
//   i_consume_valid/length     decoder retires 1..16 bytes
//   i_flush               discard all contents (wins over write and consume)
//   o_error               sticky protocol error (INSTRUCTION_QUEUE_ERROR_CHECK_EN only)
module instruction_queue #(
    parameter int DEPTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_fetch_valid,
    input  logic [31:0]              i_fetch_data,
    input  logic [2:0]               i_fetch_count,
    output logic                     o_fetch_ready,
    output logic [7:0]               o_instruction [0:15],
    output logic [$clog2(DEPTH):0]   o_available,
    input  logic                     i_consume_valid,
    input  logic [4:0]               i_consume_length,
    input  logic                     i_flush,
    output logic                     o_error
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [0:DEPTH-1];
    logic [AW-1:0] r_rd, r_wr;
    logic [CW-1:0] r_cnt;
    logic          w_fetch_ok, w_consume_ok, w_wr_en, w_rd_en;
    logic [CW-1:0] w_wr_n, w_rd_n;

`ifdef INSTRUCTION_QUEUE_ERROR_CHECK_EN
    logic r_error;
    assign w_fetch_ok   = (i_fetch_count != 3'd0) && (i_fetch_count <= 3'd4);
    assign w_consume_ok = (i_consume_length != 5'd0) && (i_consume_length <= 5'd16) &&
                          (CW'(i_consume_length) <= r_cnt);
    assign o_error      = r_error;
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst)
            r_error <= 1'b0;
        else if ((i_consume_valid && !w_consume_ok) || (i_fetch_valid && o_fetch_ready && !w_fetch_ok))
            r_error <= 1'b1;
`else
    assign w_fetch_ok   = 1'b1;
    assign w_consume_ok = 1'b1;
    assign o_error      = 1'b0;
`endif

    assign o_fetch_ready = r_cnt <= CW'(DEPTH - 4);
    assign o_available   = r_cnt;
    assign w_wr_en       = i_fetch_valid && o_fetch_ready && w_fetch_ok;
    assign w_rd_en       = i_consume_valid && w_consume_ok;
    assign w_wr_n        = w_wr_en ? CW'(i_fetch_count) : '0;
    assign w_rd_n        = w_rd_en ? CW'(i_consume_length) : '0;

    // Byte store needs no reset: bytes outside the held count are masked in the window.
    always_ff @(posedge i_clk)
        for (int k = 0; k < 4; k++)
            if (w_wr_en && !i_flush && k < int'(i_fetch_count))
                r_mem[r_wr + AW'(k)] <= i_fetch_data[8*k +: 8];

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            r_rd  <= r_rd + AW'(w_rd_n);
            r_wr  <= r_wr + AW'(w_wr_n);
            r_cnt <= r_cnt + w_wr_n - w_rd_n;
        end

    always_comb
        for (int i = 0; i < 16; i++)
            o_instruction[i] = (CW'(i) < r_cnt) ? r_mem[r_rd + AW'(i)] : 8'h00;
endmodule

// File: tb/tb_instruction_queue.sv
// tb_instruction_queue: directed scoreboard bench for instruction_queue.
module tb_instruction_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fv = 1'b0, cv = 1'b0, fl = 1'b0;
    logic [31:0] fd = '0;
    logic [2:0]  fc = '0;
    logic [4:0]  cl = '0;
    logic        ready, err;
    logic [7:0]  instr [0:15];
    logic [5:0]  avail;

    byte unsigned q[$];
    bit           err_exp = 1'b0;
    int           total = 0, bad = 0;

    always #5 clk = ~clk;

    instruction_queue #(.DEPTH(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_fetch_valid(fv), .i_fetch_data(fd), .i_fetch_count(fc),
        .o_fetch_ready(ready), .o_instruction(instr), .o_available(avail),
        .i_consume_valid(cv), .i_consume_length(cl), .i_flush(fl),
        .o_error(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":avail"}, 32'(avail), q.size());
        chk({tag, ":ready"}, 32'(ready), 32'((32 - q.size()) >= 4));
        chk({tag, ":error"}, 32'(err), 32'(err_exp));
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s:win%0d", tag, i), 32'(instr[i]), (i < q.size()) ? 32'(q[i]) : 32'h0);
    endtask

    task automatic step(input logic f_v, input logic [31:0] f_d, input logic [2:0] f_c,
                        input logic c_v, input logic [4:0] c_l, input logic f_l);
        bit acc_w, acc_c, f_ok, rdy;
        fv = f_v; fd = f_d; fc = f_c; cv = c_v; cl = c_l; fl = f_l;
        rdy   = (32 - q.size()) >= 4;
        f_ok  = f_c >= 1 && f_c <= 4;
        acc_w = f_v && rdy && f_ok;
        acc_c = c_v && c_l >= 1 && c_l <= 16 && int'(c_l) <= q.size();
`ifdef INSTRUCTION_QUEUE_ERROR_CHECK_EN
        if ((c_v && !acc_c) || (f_v && rdy && !f_ok)) err_exp = 1'b1;
`endif
        @(posedge clk);
        #1;
        if (f_l) q.delete();
        else begin
            if (acc_c) repeat (int'(c_l)) void'(q.pop_front());
            if (acc_w) for (int k = 0; k < int'(f_c); k++) q.push_back(f_d[8*k +: 8]);
        end
        fv = 1'b0; cv = 1'b0; fl = 1'b0; fc = '0; cl = '0; fd = '0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_all("reset");

        // fill and read
        step(1, 32'h03020100, 4, 0, 0, 0);
        step(1, 32'h07060504, 4, 0, 0, 0);
        check_all("fill");
        chk("fill:avail8", 32'(avail), 8);
        chk("fill:w7", 32'(instr[7]), 32'h07);
        chk("fill:w8", 32'(instr[8]), 32'h00);

        // simultaneous consume and write
        step(1, 32'h0B0A0908, 4, 1, 3, 0);
        check_all("simul");
        chk("simul:avail9", 32'(avail), 9);
        chk("simul:w0", 32'(instr[0]), 32'h03);
        chk("simul:w8", 32'(instr[8]), 32'h0B);

        // full
        step(0, 0, 0, 0, 0, 1);
        for (int n = 0; n < 20 && ready; n++) begin
            step(1, $urandom, 4, 0, 0, 0);
            check_all("fillup");
        end
        chk("full:avail32", 32'(avail), 32);
        chk("full:ready0", 32'(ready), 0);
        step(1, 32'hDEADBEEF, 4, 0, 0, 0);
        check_all("full:hold");
        step(0, 0, 0, 1, 4, 0);
        check_all("full:consume4");
        chk("full:ready1", 32'(ready), 1);

        // wrap-around: bring both pointers to 30
        step(0, 0, 0, 0, 0, 1);
        for (int n = 0; n < 7; n++) step(1, $urandom, 4, 0, 0, 0);
        step(1, $urandom, 2, 0, 0, 0);
        step(0, 0, 0, 1, 16, 0);
        step(0, 0, 0, 1, 14, 0);
        check_all("wrap:empty");
        step(1, 32'hDDCCBBAA, 4, 0, 0, 0);
        check_all("wrap");
        chk("wrap:w0", 32'(instr[0]), 32'hAA);
        chk("wrap:w3", 32'(instr[3]), 32'hDD);

        // random legal traffic
        for (int n = 0; n < 60; n++) begin
            int len;
            len = (q.size() == 0) ? 0 : $urandom_range(((q.size() < 16) ? q.size() : 16), 1);
            step($urandom_range(1, 0), $urandom, 3'($urandom_range(4, 1)), len != 0 && $urandom_range(1, 0), 5'(len), 0);
            check_all("rand");
        end

        // flush priority
        step(0, 0, 0, 0, 0, 1);
        step(1, 32'h44332211, 4, 0, 0, 0);
        step(1, 32'h88776655, 4, 0, 0, 0);
        step(1, 32'h0000AA99, 2, 0, 0, 0);
        chk("flush:pre10", 32'(avail), 10);
        step(1, 32'h12345678, 4, 1, 2, 1);
        check_all("flush");
        chk("flush:avail0", 32'(avail), 0);
        step(1, 32'h00000055, 1, 0, 0, 0);
        check_all("flush:next");
        chk("flush:w0", 32'(instr[0]), 32'h55);

`ifdef INSTRUCTION_QUEUE_ERROR_CHECK_EN
        step(0, 0, 0, 0, 0, 1);
        step(1, 32'h0000BBAA, 2, 0, 0, 0);
        step(0, 0, 0, 1, 5, 0);
        check_all("err:len");
        chk("err:flag", 32'(err), 1);
        chk("err:avail2", 32'(avail), 2);
        step(0, 0, 0, 0, 0, 1);
        check_all("err:sticky");
`endif

        // asynchronous reset mid-stream
        step(1, 32'h04030201, 4, 0, 0, 0);
        fv = 1'b1; fd = 32'hCAFEF00D; fc = 3'd4; cv = 1'b1; cl = 5'd1;
        #2 rst = 1'b1;
        #1;
        q.delete();
        err_exp = 1'b0;
        check_all("async_rst");
        fv = 1'b0; cv = 1'b0; fc = '0; cl = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_rst");
        step(1, 32'h00000077, 1, 0, 0, 0);
        check_all("post_rst:write");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instruction_queue.md
# instruction_queue

Byte-granular prefetch queue between the bus unit and the decode unit. Accepts little-endian fetch words of 1–4 bytes from the bus unit and buffers them in a circular byte store. Presents the oldest 16 bytes as the `i_instruction[0:15]` window consumed by `decode_field` and the decode logic. Retires a variable number of bytes when the decoder reports an instruction length, and supports a flush on control transfer.

## Interface
- `DEPTH`, 32: byte capacity; power of two, ≥ 20.
- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_fetch_valid`  in  1  fetch word offered.
- `i_fetch_data`  in  32  fetch bytes; byte k = bits [8k+7:8k], byte 0 oldest.
- `i_fetch_count`  in  3  number of valid low bytes, 1–4.
- `o_fetch_ready`  out  1  free space ≥ 4 bytes.
- `o_instruction`  out  8 × [0:15]  window; `o_instruction[0]` = head byte.
- `o_available`  out  $clog2(DEPTH)+1  bytes held.
- `i_consume_valid`  in  1  decoder retires bytes.
- `i_consume_length`  in  5  bytes retired, 1–16.
- `i_flush`  in  1  discard all contents.
- `o_error`  out  1  sticky protocol error.

## Operation
- **State:**
  - byte array `mem[DEPTH]`
  - head pointer `rd` and tail pointer `wr`, each $clog2(DEPTH) bits, wrapping modulo DEPTH
  - count `cnt`, 0..DEPTH
- **Write:** a write occurs when `i_fetch_valid & o_fetch_ready`.
  - Byte k (k < `i_fetch_count`) goes to `mem[(wr+k) mod DEPTH]`.
  - `wr += i_fetch_count`.
- **Ready:** `o_fetch_ready = (DEPTH - cnt) ≥ 4`, combinational from registered `cnt`. It does not depend on the same-cycle consume.
- **Window:**
  - `o_instruction[i] = mem[(rd+i) mod DEPTH]` for i < `cnt`.
  - `o_instruction[i] = 8'h00` for i ≥ `cnt`.
- **Consume:** `rd += i_consume_length`.
- **Count update:** `cnt_next = cnt + written - consumed`. Simultaneous write and consume are both applied in the same cycle.
- **Flush:** sets `rd = wr = 0` and `cnt = 0`.
  - Flush overrides write and consume in the same cycle; the fetch word is dropped.
  - `o_error` is unaffected by flush.
- **Wrap-around:** pointer arithmetic truncates to $clog2(DEPTH) bits. Windows spanning the wrap point read correctly.

## Timing
- **Reset values:**
  - `o_available` = 0
  - `o_instruction` = all `8'h00`
  - `o_fetch_ready` = 1
  - `o_error` = 0
  - pointers = 0
- **Reset mid-operation:** reset asserted in any cycle clears state immediately (asynchronous). In-flight writes and consumes are lost.
- **Write-to-visible latency:** 1 cycle. A byte written at edge N appears in the window and in `o_available` after edge N.
- **Consume latency:** 1 cycle. After the edge, the window is shifted by `i_consume_length`.
- **Full:** with `cnt` > DEPTH-4, `o_fetch_ready` = 0. An offered word is not accepted and the bus unit holds it.
- **Empty:**
  - `o_available` = 0 and the window is all zero.
  - A consume while empty is an error case (see Configuration).
- The window is combinational from registers only; there is no path from any input to `o_instruction` or `o_available`.

## Configuration
- **Macro:** `INSTRUCTION_QUEUE_ERROR_CHECK_EN`.
- **Defined:** the following conditions set `o_error` = 1 at the next edge, and the offending operation is ignored:
  - `i_consume_valid` with `i_consume_length` = 0
  - `i_consume_valid` with `i_consume_length` > 16
  - `i_consume_valid` with `i_consume_length` > `cnt`
  - an accepted fetch with `i_fetch_count` = 0 or `i_fetch_count` > 4
  
  A legal operation in the same cycle still proceeds. `o_error` clears only on reset.
- **Undefined:**
  - `o_error` is tied to 0 and no checks are made.
  - Illegal operations are outside contract; the pointers advance by the supplied value truncated to width.

## Test plan
- **Fill and read:** after reset, write `0x03020100` (count 4), then `0x07060504` (count 4) -> `o_available` = 8; `o_instruction[0..7]` = 00..07; `[8..15]` = 00.
- **Simultaneous consume and write:** from above, consume 3 together with a write of `0x0B0A0908` (count 4) -> `o_available` = 9; `o_instruction[0]` = 03, `[8]` = 0B.
- **Full:**
  - write 4-byte words until `o_fetch_ready` = 0 -> `o_available` = 32.
  - Holding `i_fetch_valid` high -> count unchanged.
  - Consume 4 -> ready = 1 next cycle.
- **Wrap-around:** advance the pointers to 30, then write `0xDDCCBBAA` -> `o_instruction[0..3]` = AA BB CC DD across the wrap.
- **Flush priority:** with 10 bytes held, assert flush, write and consume 2 in the same cycle -> `o_available` = 0, window all 00, next write lands at `o_instruction[0]`.
- **Error (macro defined):** with 2 bytes held, consume 5 -> `o_error` = 1, `o_available` still 2. A subsequent reset mid-stream -> all outputs return to reset values.
